rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-back arbiter and register scoreboard for the 64-bit register file's single write port. It merges two result sources into one `RegWrite`/`RD`/`WriteData` stream: in-order pipeline write-back and the multi-cycle mul/div unit (MDU). It tracks destination registers with an outstanding MDU result and raises RAW/WAW stall requests to decode. It also enforces x0 as read-only, which the register file itself does not do.

## Interface
- `XLEN`, default 64: data width.
- `NREG`, default 32: number of architectural registers.
- `STARVE_LIMIT`, default 4: consecutive cycles an MDU result may be refused before `starve_hold` is raised.
- `clk` input 1: clock. The scoreboard updates on posedge. The register file samples the write port on negedge.
- `reset` input 1: synchronous, active-high.
- `pipe_wb_valid` input 1: pipeline WB stage holds a register write.
- `pipe_wb_rd` input 5: pipeline destination register.
- `pipe_wb_data` input XLEN: pipeline write data.
- `mdu_issue_valid` input 1: an MDU op is issued this cycle.
- `mdu_issue_rd` input 5: destination register of the issued MDU op.
- `mdu_wb_valid` input 1: the MDU offers a result.
- `mdu_wb_rd` input 5: destination register of the MDU result.
- `mdu_wb_data` input XLEN: MDU result data.
- `mdu_wb_ready` output 1: the MDU result is accepted this cycle.
- `id_rs1`, `id_rs2` input 5: decode-stage source registers.
- `id_rd` input 5: decode-stage destination register.
- `id_rd_valid` input 1: the decode instruction writes `id_rd`.
- `stall_raw` output 1: a decode source register is pending.
- `stall_waw` output 1: the decode destination register is pending.
- `starve_hold` output 1: request to the hazard unit to inject bubbles.
- `RegWrite` output 1: write enable to the register file.
- `RD` output 5: write address to the register file.
- `WriteData` output XLEN: write data to the register file.
- `busy_mask` output NREG: registered scoreboard, exported for debug.

## Operation
- Pipeline WB has absolute priority, because the pipeline cannot stall at WB.
  - `mdu_wb_ready = !reset && (!pipe_wb_valid || pipe_wb_rd == 0)`.
  - A pipeline write to x0 is a free slot.
- Write mux, combinational:
  - If `pipe_wb_valid` and `pipe_wb_rd != 0`, drive the pipeline rd/data.
  - Else, if the MDU handshake fires (`mdu_wb_valid && mdu_wb_ready`) and `mdu_wb_rd != 0`, drive the MDU rd/data.
  - Else drive `RegWrite = 0`, `RD = 0`, `WriteData = 0`.
- Scoreboard `busy_mask[NREG-1:0]`:
  - Set on posedge for `mdu_issue_rd` when `mdu_issue_valid` and rd != 0.
  - Cleared on posedge for `mdu_wb_rd` when the MDU handshake fires.
  - Set and clear of the same bit in one cycle: set wins, because the new op is outstanding.
  - Bit 0 is always 0.
- Hazards, combinational:
  - `stall_raw` = (`busy_mask[id_rs1]` and not retiring) OR (`busy_mask[id_rs2]` and not retiring). "Retiring" means the MDU handshake fires this cycle with `mdu_wb_rd` equal to that source. The negedge write lands before decode's posedge capture, so the retiring register is readable without a stall.
  - `stall_waw = id_rd_valid && id_rd != 0 && busy_mask[id_rd]`. There is no retire bypass for WAW.
  - x0 sources never stall.
- Starvation:
  - `starve_cnt` increments each cycle `mdu_wb_valid && !mdu_wb_ready` holds, saturating at `STARVE_LIMIT`.
  - It clears on a handshake or when `mdu_wb_valid` is 0.
  - `starve_hold` is registered. It sets on the posedge where `starve_cnt` reaches `STARVE_LIMIT-1` and is still refused. It clears on the posedge after the MDU handshake.
- Issue to a busy register is prevented upstream by `stall_waw`. If it occurs anyway, the bit stays set; no error is flagged.

## Timing
- Write port: zero latency from inputs to `RegWrite`/`RD`/`WriteData` (combinational). Data is committed at the negedge of the same cycle.
- Scoreboard: visible one cycle after issue.
  - Issue at cycle N: `busy_mask` bit is 1 from N+1.
  - `stall_raw` for that rd asserts at N+1. It does not assert at N; same-cycle issue/decode pairs are the hazard unit's job.
- MDU result: accepted in the first cycle with no competing pipeline write. A result held with `mdu_wb_valid` must keep rd/data stable until accepted.
- `starve_hold`: worst case, it asserts `STARVE_LIMIT` cycles after the first refusal.
- Reset, while asserted, including mid-operation:
  - `RegWrite=0`, `RD=0`, `WriteData=0`, `mdu_wb_ready=0`, `stall_raw=0`, `stall_waw=0`.
  - `busy_mask` and `starve_cnt` clear and `starve_hold=0` at the first posedge with reset high.
  - In-flight MDU results are dropped.

## Test plan
- Issue MDU rd=5 at cycle 0, no pipeline writes, result data 0xDEAD at cycle 3: `busy_mask[5]=1` for cycles 1–3. `RegWrite=1, RD=5, WriteData=0xDEAD` at cycle 3. `busy_mask=0` at cycle 4.
- Pipeline WB rd=7 and MDU result rd=9 in the same cycle: `RD=7`, `mdu_wb_ready=0`. Next cycle with no pipeline write: `RD=9`, ready=1.
- rd=0 cases: pipeline WB rd=0 with an MDU result pending gives MDU accepted, `RD` = MDU rd. MDU issue rd=0 gives `busy_mask` stays 0. MDU result rd=0 gives `RegWrite=0`.
- `busy_mask[4]=1`, `id_rs1=4`: `stall_raw=1`. In the cycle the MDU handshake fires with rd=4: `stall_raw=0`. `id_rd=4, id_rd_valid=1` that cycle: `stall_waw=1`.
- Continuous pipeline writes with an MDU result pending, `STARVE_LIMIT=4`: `starve_hold=1` after 4 refused cycles. Drop the pipeline writes: handshake fires, `starve_hold=0` the next cycle.
- Reset asserted with `busy_mask=0x0000_0120` and `starve_hold=1`: next cycle `busy_mask=0`, `starve_hold=0`, all outputs 0 while reset is high.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges pipeline write-back and the MDU result onto the single
// register-file write port. It keeps a scoreboard of registers with an
// outstanding MDU result and raises RAW/WAW stalls and a starvation hold.
// Latency: the write port is combinational and commits at the negedge of the
// same cycle. The scoreboard and starve_hold are registered, one cycle.
// Backpressure: pipeline WB is never refused. The MDU is refused (mdu_wb_ready=0)
// whenever the pipeline writes a non-x0 register.
//
// Ports: clk/reset (sync, active-high); pipe_wb_* (pipeline WB);
// mdu_issue_* (MDU issue); mdu_wb_* (MDU result valid/ready);
// id_* (decode operands); stall_raw/stall_waw/starve_hold (to hazard unit);
// RegWrite/RD/WriteData (register-file write port); busy_mask (debug).
module rf_wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int NREG         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_wb_valid,
    input  logic [4:0]      pipe_wb_rd,
    input  logic [XLEN-1:0] pipe_wb_data,
    input  logic            mdu_issue_valid,
    input  logic [4:0]      mdu_issue_rd,
    input  logic            mdu_wb_valid,
    input  logic [4:0]      mdu_wb_rd,
    input  logic [XLEN-1:0] mdu_wb_data,
    output logic            mdu_wb_ready,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_rd_valid,
    output logic            stall_raw,
    output logic            stall_waw,
    output logic            starve_hold,
    output logic            RegWrite,
    output logic [4:0]      RD,
    output logic [XLEN-1:0] WriteData,
    output logic [NREG-1:0] busy_mask
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM    = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] LIM_M1 = CW'(STARVE_LIMIT - 1);

    logic            pipe_wr;
    logic            mdu_hs;
    logic            refused;
    logic            ret_rs1;
    logic            ret_rs2;
    logic [NREG-1:0] busy_nxt;
    logic [CW-1:0]   starve_cnt;

    // A pipeline write to x0 carries nothing, so it leaves the slot free.
    assign pipe_wr      = pipe_wb_valid && (pipe_wb_rd != 5'd0);
    assign mdu_wb_ready = !reset && !pipe_wr;
    assign mdu_hs       = mdu_wb_valid && mdu_wb_ready;
    assign refused      = mdu_wb_valid && !mdu_wb_ready;

    // Write port mux. x0 writes from either source are suppressed here
    // because the register file does not protect x0 itself.
    always_comb begin
        RegWrite  = 1'b0;
        RD        = 5'd0;
        WriteData = '0;
        if (!reset) begin
            if (pipe_wr) begin
                RegWrite  = 1'b1;
                RD        = pipe_wb_rd;
                WriteData = pipe_wb_data;
            end else if (mdu_hs && (mdu_wb_rd != 5'd0)) begin
                RegWrite  = 1'b1;
                RD        = mdu_wb_rd;
                WriteData = mdu_wb_data;
            end
        end
    end

    // Scoreboard next state: clear on retire first, so a same-cycle issue to
    // the same register leaves it set (the new op is outstanding).
    always_comb begin
        busy_nxt = busy_mask;
        if (mdu_hs) begin
            busy_nxt[mdu_wb_rd] = 1'b0;
        end
        if (mdu_issue_valid && (mdu_issue_rd != 5'd0)) begin
            busy_nxt[mdu_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_nxt;
        end
    end

    // A source retiring this cycle is written at the negedge, before decode
    // captures it, so it does not need a RAW stall.
    assign ret_rs1 = mdu_hs && (mdu_wb_rd == id_rs1);
    assign ret_rs2 = mdu_hs && (mdu_wb_rd == id_rs2);

    always_comb begin
        stall_raw = 1'b0;
        stall_waw = 1'b0;
        if (!reset) begin
            stall_raw = ((id_rs1 != 5'd0) && busy_mask[id_rs1] && !ret_rs1) ||
                        ((id_rs2 != 5'd0) && busy_mask[id_rs2] && !ret_rs2);
            stall_waw = id_rd_valid && (id_rd != 5'd0) && busy_mask[id_rd];
        end
    end

    // Starvation: count consecutive refusals. The hold is raised on the
    // refusal that brings the count to the limit, and dropped after the
    // result finally gets through.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt  <= '0;
            starve_hold <= 1'b0;
        end else begin
            if (!mdu_wb_valid || mdu_hs) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (mdu_hs) begin
                starve_hold <= 1'b0;
            end else if (refused && (starve_cnt >= LIM_M1)) begin
                starve_hold <= 1'b1;
            end
        end
    end

endmodule
